// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  // Width of the memory latency down-counter (MEM_LATENCY up to 15).
  localparam int CNT_W = 4;

  // Encoding of the last_grant bit: 1 = D side was served last.
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selector for the memory port arbiter.
// Default build: fixed priority, D beats I.
// With MEM_ARB_FAIR_EN defined: a tie goes to the side not served last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   last_grant,
  output grant_t grant
);

`ifndef MEM_ARB_FAIR_EN
  // Fixed priority ignores the history bit.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Choose a requester; a lone request always wins.
  always_comb begin
    // NOTE: default assigned first so every path drives grant and no latch is inferred.
    grant = GNT_NONE;
    if (i_req && d_req) begin
`ifdef MEM_ARB_FAIR_EN
      grant = (last_grant == LAST_D) ? GNT_I : GNT_D;
`else
      grant = GNT_D;
`endif
    end else if (d_req) begin
      grant = GNT_D;
    end else if (i_req) begin
      grant = GNT_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data memory between the
// instruction-fetch (I) and load/store (D) units of the multicycle core.
// Each access runs IDLE -> ACCESS (MEM_LATENCY cycles) -> RESP.
// Read data is captured on the last ACCESS edge so the ready pulse and
// its rdata appear together in the RESP cycle.
// Optional macro MEM_ARB_FAIR_EN: round-robin tie-break instead of D priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [0:ADDR_W-1] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [0:ADDR_W-1] d_addr,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic              d_half,
  input  logic              d_sext,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic [0:ADDR_W-1] mem_addr,
  output logic              mem_write_enable,
  output logic              mem_byte,
  output logic              mem_half_word,
  output logic              mem_sign_extend,
  output logic [DATA_W-1:0] mem_data_out,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  grant_t           grant;
  grant_t           pick;
  logic [CNT_W-1:0] cnt;
  logic             cmd_we;
  logic             last_grant;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Access sequencer: arbitrate in IDLE, hold the command through ACCESS, respond in RESP.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (!reset) begin
      state            <= IDLE;
      grant            <= GNT_NONE;
      cnt              <= '0;
      cmd_we           <= 1'b0;
      i_ready          <= 1'b0;
      d_ready          <= 1'b0;
      i_rdata          <= '0;
      d_rdata          <= '0;
      mem_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_byte         <= 1'b0;
      mem_half_word    <= 1'b0;
      mem_sign_extend  <= 1'b0;
      mem_data_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            grant <= pick;
            cnt   <= LAT_M1;
            state <= ACCESS;
            if (pick == GNT_D) begin
              cmd_we           <= d_we;
              mem_addr         <= d_addr;
              mem_write_enable <= d_we;
              mem_byte         <= d_byte;
              mem_half_word    <= d_half;
              mem_sign_extend  <= d_sext;
              mem_data_out     <= d_wdata;
            end else begin
              // Fetches are always plain word reads.
              cmd_we           <= 1'b0;
              mem_addr         <= i_addr;
              mem_write_enable <= 1'b0;
              mem_byte         <= 1'b0;
              mem_half_word    <= 1'b0;
              mem_sign_extend  <= 1'b0;
              mem_data_out     <= '0;
            end
          end
        end

        ACCESS: begin
          // A store writes only in the first ACCESS cycle.
          mem_write_enable <= 1'b0;
          if (cnt == '0) begin
            state           <= RESP;
            mem_addr        <= '0;
            mem_byte        <= 1'b0;
            mem_half_word   <= 1'b0;
            mem_sign_extend <= 1'b0;
            mem_data_out    <= '0;
            if (grant == GNT_D) begin
              d_ready <= 1'b1;
              if (!cmd_we) begin
                d_rdata <= mem_data_in;
              end
            end else begin
              i_ready <= 1'b1;
              i_rdata <= mem_data_in;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          i_ready <= 1'b0;
          d_ready <= 1'b0;
          grant   <= GNT_NONE;
          cmd_we  <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_FAIR_EN
  logic last_grant_q;

  // Remember which side was granted most recently for the round-robin tie-break.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q <= LAST_D;
    end else if (state == IDLE && pick != GNT_NONE) begin
      last_grant_q <= (pick == GNT_D) ? LAST_D : ~LAST_D;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = LAST_D;
`endif

  assign busy = (state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port byte-addressable data memory between two requesters of the multicycle processor: the instruction-fetch unit (I side, read-only word) and the load/store unit (D side, byte/half/word, signed or unsigned).
- Sits between the processor core and the memory model.
- Sequences each access through a fixed-latency memory transaction.
- Returns the response to the granted requester with a one-cycle ready pulse.

Parameters:
- ADDR_W, 32, address width; bit 0 is the MSB, matching the codebase [0:N-1] ordering.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles the memory command is held before read data is valid; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_ready.
- i_addr  in  ADDR_W  fetch word address.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held high until d_ready.
- d_addr  in  ADDR_W  data address.
- d_we  in  1  1 = store, 0 = load.
- d_byte  in  1  byte access.
- d_half  in  1  half-word access.
- d_sext  in  1  sign-extend loads.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load result.
- mem_addr  out  ADDR_W  to memory addr.
- mem_write_enable  out  1  to memory write_enable.
- mem_byte  out  1  to memory mem_byte.
- mem_half_word  out  1  to memory mem_half_word.
- mem_sign_extend  out  1  to memory sign_extend.
- mem_data_out  out  DATA_W  to memory data_in.
- mem_data_in  in  DATA_W  from memory data_out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP. Grant register: NONE, I, D.
- Reset (asserted low, asynchronous):
  - state = IDLE, grant = NONE.
  - i_ready, d_ready, mem_write_enable, busy = 0.
  - All mem_* command and data outputs = 0.
  - i_rdata, d_rdata = 0.
- IDLE:
  - Samples the request lines.
  - Grant rule when both are high: D wins (fixed priority).
  - On grant, latches the command (addr, we, byte, half, sext, wdata), loads the latency counter with MEM_LATENCY-1, and moves to ACCESS.
  - I grants force byte = half = we = 0 and sext = 0.
- ACCESS:
  - Drives the latched command on the mem_* outputs.
  - mem_write_enable is high only in the first ACCESS cycle, so a store writes exactly once.
  - Counter decrements each cycle; at 0 the state moves to RESP.
- RESP:
  - Captures mem_data_in into the granted side's rdata register.
  - Pulses that side's ready for exactly one cycle.
  - Returns to IDLE.
  - mem_* outputs return to 0.
- Latency: a request first seen high in IDLE at cycle N produces ready at cycle N+MEM_LATENCY+1. Example: MEM_LATENCY = 1 gives ready at N+2. Back-to-back accesses have a minimum spacing of MEM_LATENCY+2 cycles per access.
- Handshake:
  - A requester drops req in the cycle after its ready pulse.
  - If req is still high in the following IDLE, it is treated as a new request.
  - The rdata registers hold their value until the next completion on the same side.
  - Stores also pulse d_ready; d_rdata is then unchanged.
- Boundary cases:
  - req deasserted mid-transaction: the access completes (a store is still written) and the ready pulse still fires.
  - Both requests arriving while busy: they wait; arbitration happens only in IDLE.
  - Reset mid-ACCESS: aborts immediately; no further mem_write_enable; outputs go to their reset values.
  - Address alignment is not checked; the memory handles it.
- busy mirrors (state != IDLE).

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - Adds a 1-bit last_grant register (reset = D).
  - When both requests are pending in IDLE, grant goes to the side not granted last.
  - A single pending request is granted regardless of last_grant.
- Undefined: fixed D-over-I priority; no last_grant register exists.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the grant encoding (GNT_NONE, GNT_I, GNT_D);
  - the counter width constant CNT_W = 4.
- One sub-module is natural: mem_arb_pick, a combinational grant selector. Inputs: i_req, d_req, last_grant. Output: the grant. The MEM_ARB_FAIR_EN logic is confined to it.
- The FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- Single fetch, MEM_LATENCY = 1: i_req with i_addr = 0x00000010 at cycle N; memory word 0x8cc42000.
  - i_ready at N+2 with i_rdata = 0x8cc42000.
  - mem_write_enable stays 0 throughout.
- Simultaneous requests: i_req and d_req (load, 0x2000) raised in the same IDLE cycle.
  - D completes first.
  - I is granted in the following IDLE.
  - With MEM_ARB_FAIR_EN, a second simultaneous pair is granted to I first.
- Byte store then load, MEM_LATENCY = 3:
  - Store 0xFF to 0x2003 with d_byte = 1: mem_write_enable high for exactly 1 cycle; d_ready 4 cycles after the request.
  - Load of the same byte with d_sext = 1 returns d_rdata = 0xFFFFFFFF.
- Request drop: d_req for a store held only 1 cycle.
  - Memory is still written.
  - d_ready still pulses once.
- Reset mid-ACCESS: reset pulled low during the second ACCESS cycle.
  - All outputs immediately take their reset values.
  - After release with no requests, busy = 0 and no ready pulse is issued.
